multiword_adder_seq: RTL and testbench

- Sequential wide adder that adds two DATA_W-bit operands N bits per cycle, LSB slice first.
- Uses one carry_select_adder instance (parameters N, SIZE). A registered carry links consecutive slices.
- Sits upstream of the carry_select_adder and drives it. It also captures the adder's sum and carry each cycle.
- Trades latency for area where a full-width CSLA would be too large. Valid/ready on both sides.

---
 rtl/multiword_adder_seq_if.sv | 27 ++
 rtl/multiword_adder_seq.sv | 141 ++++++++++++++
 tb/tb_multiword_adder_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multiword_adder_seq_if.sv
// Operand/result handshake bundle for the sequential multiword adder.
// The master side supplies operands and accepts results; the slave side is the adder.
interface multiword_adder_seq_if #(
   parameter int DATA_W = 128
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              cin;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] sum;
   logic              cout;
   logic              overflow;
   logic              busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, overflow, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, overflow, busy
   );
endinterface

// File: rtl/multiword_adder_seq.sv
// Sequential wide adder: pushes N-bit slices through one carry-select adder, LSB first,
// chaining the carry through a register between slices.

module carry_select_adder #(
   parameter int N    = 32,
   parameter int SIZE = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   localparam int BLOCKS = N / SIZE;

   logic [BLOCKS:0] c;
   assign c[0] = cin;

   // Each block precomputes both carry-in cases; the incoming carry only selects.
   for (genvar g = 0; g < BLOCKS; g++) begin : g_blk
      logic [SIZE:0] r0;
      logic [SIZE:0] r1;
      assign r0 = {1'b0, a[g*SIZE +: SIZE]} + {1'b0, b[g*SIZE +: SIZE]};
      assign r1 = r0 + {{SIZE{1'b0}}, 1'b1};
      assign sum[g*SIZE +: SIZE] = c[g] ? r1[SIZE-1:0] : r0[SIZE-1:0];
      assign c[g+1]              = c[g] ? r1[SIZE]     : r0[SIZE];
   end

   assign cout = c[BLOCKS];
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one slice per cycle through the CSLA, counter selects the slice
// DONE  | result held with out_valid until the consumer takes it
module multiword_adder_seq #(
   parameter int DATA_W = 128,
   parameter int N      = 32,
   parameter int SIZE   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   multiword_adder_seq_if.slave  bus
);
   localparam int SLICES = DATA_W / N;
   localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              carry_q;
   logic [DATA_W-1:0] a_q, b_q, sum_q;
   logic              cout_q, ovf_q;

   logic              in_ready, out_valid, busy;
   logic              last_slice;
   logic [N-1:0]      csla_sum;
   logic              csla_cout;

   carry_select_adder #(.N(N), .SIZE(SIZE)) u_csla (
      .a    (a_q[cnt_q*N +: N]),
      .b    (b_q[cnt_q*N +: N]),
      .cin  (carry_q),
      .sum  (csla_sum),
      .cout (csla_cout)
   );

   assign last_slice = (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_slice) state_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  carry_q <= bus.cin;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               sum_q[cnt_q*N +: N] <= csla_sum;
               carry_q             <= csla_cout;
               cnt_q               <= cnt_q + 1'b1;
               // The top slice carries the result MSB, so overflow is settled here.
               if (last_slice) begin
                  cout_q <= csla_cout;
                  ovf_q  <= (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                            (csla_sum[N-1] != a_q[DATA_W-1]);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.overflow  = ovf_q & out_valid;
endmodule

// File: tb/tb_multiword_adder_seq.sv
// Bench for multiword_adder_seq: directed vectors feed an expected-result queue,
// a negedge monitor pops and compares on every output handshake.
module tb_multiword_adder_seq;
   localparam int DATA_W = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multiword_adder_seq_if #(.DATA_W(DATA_W)) bus ();

   multiword_adder_seq #(.DATA_W(DATA_W), .N(32), .SIZE(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int pushed = 0;
   int popped = 0;
   logic [DATA_W+1:0] exp_q[$];   // {overflow, cout, sum}

   task automatic check(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference built from a plain wide add, independent of the slicing.
   function automatic logic [DATA_W+1:0] ref_result(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                     input logic cin);
      logic [DATA_W:0] full;
      logic            ovf;
      full = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
      ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (full[DATA_W-1] != a[DATA_W-1]);
      return {ovf, full};
   endfunction

   // Drives at posedge+1; returns at posedge+1 of the cycle after the accept edge.
   task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic cin,
                       input logic [DATA_W+1:0] exp, input bit push);
      int budget;
      budget = 0;
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      while (!bus.in_ready && budget < 200) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout", 1'b0, 1'b1);
      end else begin
         if (push) begin
            exp_q.push_back(exp);
            pushed++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.cin      = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [DATA_W+1:0] e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1'b1, 1'b0);
         end else begin
            e = exp_q.pop_front();
            popped++;
            check("sum",      {1'b0, bus.sum},              {1'b0, e[DATA_W-1:0]});
            check("cout",     {{DATA_W{1'b0}}, bus.cout},     {{DATA_W{1'b0}}, e[DATA_W]});
            check("overflow", {{DATA_W{1'b0}}, bus.overflow}, {{DATA_W{1'b0}}, e[DATA_W+1]});
         end
      end
   end

   initial begin
      logic [DATA_W-1:0] ones, msb, maxpos, ra, rb;
      logic              rc;
      int                budget;
      bit                rand_done;
      ones   = '1;
      msb    = {1'b1, {(DATA_W-1){1'b0}}};
      maxpos = ~msb;

      idle_inputs();
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready",  {128'd0, bus.in_ready},  129'd1);
      check("rst_out_valid", {128'd0, bus.out_valid}, 129'd0);
      check("rst_sum",       {1'b0, bus.sum},         129'd0);
      check("rst_cout",      {128'd0, bus.cout},      129'd0);
      check("rst_overflow",  {128'd0, bus.overflow},  129'd0);
      check("rst_busy",      {128'd0, bus.busy},      129'd0);
      @(posedge clk); #1;

      // 1: full-width carry ripple and exact latency
      send(ones, 128'd1, 1'b0, {1'b0, 1'b1, 128'd0}, 1'b1);
      idle_inputs();
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("lat_no_valid_early", {128'd0, bus.out_valid}, 129'd0);
      end
      @(negedge clk);
      check("lat_valid_at_t5", {128'd0, bus.out_valid}, 129'd1);
      @(negedge clk);
      check("lat_valid_one_cycle", {128'd0, bus.out_valid}, 129'd0);
      check("lat_ready_returns",   {128'd0, bus.in_ready},  129'd1);
      @(posedge clk); #1;

      // 2: carry crossing slice 0 -> 1
      send(128'hFFFF_FFFF, 128'd1, 1'b0, {2'b00, 128'h1_0000_0000}, 1'b1);
      // 3: signed overflow both directions
      send(maxpos, 128'd1, 1'b0, {1'b1, 1'b0, msb}, 1'b1);
      send(msb, msb, 1'b0, {1'b1, 1'b1, 128'd0}, 1'b1);
      idle_inputs();

      // 4: cin only, then output backpressure while a new op waits
      budget = 0;
      while (bus.in_ready == 1'b0 && budget < 100) begin @(posedge clk); #1; budget++; end
      bus.out_ready = 1'b0;
      send(128'd0, 128'd0, 1'b1, {2'b00, 128'd1}, 1'b1);
      idle_inputs();
      budget = 0;
      @(negedge clk);
      while (!bus.out_valid && budget < 50) begin @(negedge clk); budget++; end
      check("hold_reached_done", {128'd0, bus.out_valid}, 129'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a        = 128'd2;
      bus.b        = 128'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_out_valid", {128'd0, bus.out_valid}, 129'd1);
         check("hold_sum",       {1'b0, bus.sum},         129'd1);
         check("hold_cout",      {128'd0, bus.cout},      129'd0);
         check("hold_in_ready",  {128'd0, bus.in_ready},  129'd0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      send(128'd2, 128'd3, 1'b0, {2'b00, 128'd5}, 1'b1);
      idle_inputs();

      // 5: reset in the second RUN cycle aborts the op
      budget = 0;
      while (bus.in_ready == 1'b0 && budget < 100) begin @(posedge clk); #1; budget++; end
      send(128'd1, 128'd1, 1'b0, '0, 1'b0);
      idle_inputs();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready",  {128'd0, bus.in_ready},  129'd1);
      check("abort_out_valid", {128'd0, bus.out_valid}, 129'd0);
      check("abort_sum",       {1'b0, bus.sum},         129'd0);
      check("abort_busy",      {128'd0, bus.busy},      129'd0);
      @(posedge clk); #1;
      send(128'd5, 128'd7, 1'b0, {2'b00, 128'd12}, 1'b1);
      idle_inputs();

      // 6: back-to-back ops with random consumer backpressure
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               ra = {$urandom, $urandom, $urandom, $urandom};
               rb = {$urandom, $urandom, $urandom, $urandom};
               rc = 1'($urandom_range(0, 1));
               send(ra, rb, rc, ref_result(ra, rb, rc), 1'b1);
            end
            idle_inputs();
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.out_ready = 1'b1;

      budget = 0;
      while (exp_q.size() != 0 && budget < 500) begin @(posedge clk); budget++; end
      @(negedge clk);
      check("pending_results", 129'(exp_q.size()), 129'd0);
      check("result_count",    129'(popped),       129'(pushed));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
